// File: rtl/ifc_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding and the instruction word width.
package ifc_pkg;

    localparam int IW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ifc_fifo.sv
// Fetch queue: DEPTH entries of W bits with a combinational head output,
// synchronous flush and asynchronous reset of the occupancy state.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifc_fifo
    import ifc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 22,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage entries carry no reset; only the occupancy tracking does.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        // Capture the pushed word into the entry addressed by the write pointer.
        always_ff @(posedge clk_i) begin
            if (push_i && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= wdata_i;
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_i && !pop_i)      count_q <= count_q + CW'(1);
            else if (pop_i && !push_i) count_q <= count_q - CW'(1);
        end
    end

    // Head reads as zero when empty so the outputs are clean after reset.
    assign rdata_o = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks the PC from RESET_PC to LAST_PC,
// pushing {PC, instruction} into a small queue drained by decode, with
// redirect (flush + new PC) support.
// Optional feature: define IFC_STALL_CNT_EN to add the STALL_CNT output,
// a saturating count of cycles spent in STALL.
module instr_fetch_ctrl
    import ifc_pkg::*;
#(
    parameter int              PC_W     = 6,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] LAST_PC  = PC_W'(7)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            RUN,
    output logic [PC_W-1:0] IM_ADDR,
    input  logic [IW-1:0]   IM_DATA,
    output logic            IR_VALID,
    output logic [IW-1:0]   IR_DATA,
    output logic [PC_W-1:0] IR_PC,
    input  logic            IR_READY,
    input  logic            REDIR_VALID,
    input  logic [PC_W-1:0] REDIR_PC,
    output logic [1:0]      STATE
`ifdef IFC_STALL_CNT_EN
    ,
    output logic [15:0]     STALL_CNT
`endif
);

    localparam int EW = PC_W + IW;
    localparam int CW = $clog2(DEPTH + 1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic            push;
    logic            pop;
    logic            will_be_full;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   fifo_head;

    // A redirect suppresses both queue operations in its cycle.
    assign pop  = !fifo_empty && IR_READY && !REDIR_VALID;
    assign push = (state_q == ST_FETCH) && (!fifo_full || pop) && !REDIR_VALID;

    // Without a pop the queue ends the cycle full if it already is, or if
    // this push takes the last free slot.
    assign will_be_full = !pop && (fifo_full || (push && (fifo_count == CW'(DEPTH - 1))));

    ifc_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .flush_i (REDIR_VALID),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({pc_q, IM_DATA}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State and PC registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and PC; redirect outranks every other event in the cycle,
    // and reaching LAST_PC outranks RUN=0.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (REDIR_VALID) begin
            pc_d = REDIR_PC;
            if (state_q != ST_IDLE) state_d = ST_FETCH;
        end else begin
            if (push) pc_d = pc_q + PC_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (RUN) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (push && (pc_q == LAST_PC)) state_d = ST_DONE;
                    else if (!RUN)                 state_d = ST_IDLE;
                    else if (will_be_full)         state_d = ST_STALL;
                end
                ST_STALL: begin
                    if (!RUN)     state_d = ST_IDLE;
                    else if (pop) state_d = ST_FETCH;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign IM_ADDR  = pc_q;
    assign STATE    = state_q;
    assign IR_VALID = !fifo_empty;
    assign IR_PC    = fifo_head[EW-1:IW];
    assign IR_DATA  = fifo_head[IW-1:0];

`ifdef IFC_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Count cycles spent in STALL, holding at the maximum value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_STALL) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Testbench for instr_fetch_ctrl: a table of per-cycle vectors for the
// straight-line fetch run, hand-written sequences for stall, redirect and
// asynchronous reset, and a randomized run against a queue-based model.
// Define IFC_STALL_CNT_EN to also exercise the STALL_CNT output.
module tb_instr_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RUN;
    logic        IR_READY;
    logic        REDIR_VALID;
    logic [5:0]  REDIR_PC;

    logic [5:0]  a_addr, a_pc, b_addr, b_pc;
    logic [15:0] a_im_data, a_data, b_im_data, b_data;
    logic        a_valid, b_valid;
    logic [1:0]  a_state, b_state;
`ifdef IFC_STALL_CNT_EN
    logic [15:0] a_stall_cnt, b_stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    // Instruction memory contents: distinct per address.
    function automatic logic [15:0] mem_word(input logic [5:0] a);
        return {4'hC, a, ~a};
    endfunction

    assign a_im_data = mem_word(a_addr);
    assign b_im_data = mem_word(b_addr);

    instr_fetch_ctrl dut0 (
        .CLK(CLK), .RST(RST), .RUN(RUN), .IM_ADDR(a_addr), .IM_DATA(a_im_data),
        .IR_VALID(a_valid), .IR_DATA(a_data), .IR_PC(a_pc), .IR_READY(IR_READY),
        .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC), .STATE(a_state)
`ifdef IFC_STALL_CNT_EN
        , .STALL_CNT(a_stall_cnt)
`endif
    );

    instr_fetch_ctrl #(.RESET_PC(6'd62), .LAST_PC(6'd1)) dut1 (
        .CLK(CLK), .RST(RST), .RUN(RUN), .IM_ADDR(b_addr), .IM_DATA(b_im_data),
        .IR_VALID(b_valid), .IR_DATA(b_data), .IR_PC(b_pc), .IR_READY(IR_READY),
        .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC), .STATE(b_state)
`ifdef IFC_STALL_CNT_EN
        , .STALL_CNT(b_stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; RUN = 1'b0; IR_READY = 1'b0; REDIR_VALID = 1'b0; REDIR_PC = 6'd0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    typedef struct {
        logic       run;
        logic       ready;
        logic       a_valid;
        logic [5:0] a_pc;
        logic [1:0] a_state;
        logic [5:0] a_addr;
        logic       b_valid;
        logic [5:0] b_pc;
        logic [1:0] b_state;
    } vec_t;

    vec_t tbl[10];

    int   mq[$];
    int   mode;
    int   mpc;
    bit   m_pop, m_push, m_last;
    logic [63:0] exp_v, act_v;

    initial begin
        // Expected per-cycle outputs of the free-running fetch with decode always ready.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 6'd0, 2'd1, 6'd0, 1'b0, 6'd0, 2'd1};
        for (int k = 1; k <= 8; k++) begin
            tbl[k].run     = 1'b1;
            tbl[k].ready   = 1'b1;
            tbl[k].a_valid = 1'b1;
            tbl[k].a_pc    = 6'(k - 1);
            tbl[k].a_state = (k == 8) ? 2'd3 : 2'd1;
            tbl[k].a_addr  = 6'(k);
            tbl[k].b_valid = (k <= 4);
            tbl[k].b_pc    = (k <= 4) ? 6'((62 + k - 1) % 64) : 6'd0;
            tbl[k].b_state = (k >= 4) ? 2'd3 : 2'd1;
        end
        tbl[9] = '{1'b1, 1'b1, 1'b0, 6'd0, 2'd3, 6'd8, 1'b0, 6'd0, 2'd3};

        // Reset state.
        do_reset();
        check("rst_valid", 64'(a_valid), 64'(0));
        check("rst_data",  64'(a_data),  64'(0));
        check("rst_pc",    64'(a_pc),    64'(0));
        check("rst_addr",  64'(a_addr),  64'(0));
        check("rst_state", 64'(a_state), 64'(0));
        check("rst_addr_b", 64'(b_addr), 64'(62));

        // Table-driven straight-line run on both instances.
        for (int i = 0; i < 10; i++) begin
            RUN = tbl[i].run;
            IR_READY = tbl[i].ready;
            step();
            check($sformatf("tbl%0d_state", i), 64'(a_state), 64'(tbl[i].a_state));
            check($sformatf("tbl%0d_addr", i),  64'(a_addr),  64'(tbl[i].a_addr));
            check($sformatf("tbl%0d_valid", i), 64'(a_valid), 64'(tbl[i].a_valid));
            if (tbl[i].a_valid) begin
                check($sformatf("tbl%0d_pc", i),   64'(a_pc),   64'(tbl[i].a_pc));
                check($sformatf("tbl%0d_data", i), 64'(a_data), 64'(mem_word(tbl[i].a_pc)));
            end
            check($sformatf("tbl%0d_b_state", i), 64'(b_state), 64'(tbl[i].b_state));
            check($sformatf("tbl%0d_b_valid", i), 64'(b_valid), 64'(tbl[i].b_valid));
            if (tbl[i].b_valid)
                check($sformatf("tbl%0d_b_pc", i), 64'(b_pc), 64'(tbl[i].b_pc));
        end

        // Stall with decode blocked, then resume.
        do_reset();
        RUN = 1'b1; IR_READY = 1'b0;
        repeat (3) step();
        check("stall_state", 64'(a_state), 64'(2));
        check("stall_addr",  64'(a_addr),  64'(2));
        check("stall_head",  64'(a_pc),    64'(0));
        step();
        check("stall_hold_state", 64'(a_state), 64'(2));
        check("stall_hold_addr",  64'(a_addr),  64'(2));
        check("stall_hold_head",  64'(a_pc),    64'(0));
        IR_READY = 1'b1;
        #1;
        check("resume_first_pc", 64'(a_pc), 64'(0));
        step();
        check("resume_state", 64'(a_state), 64'(1));
        check("resume_next_pc", 64'(a_pc), 64'(1));
        step();
        check("resume_pc2", 64'(a_pc), 64'(2));
        check("resume_addr", 64'(a_addr), 64'(3));

        // Redirect while the queue is full.
        do_reset();
        RUN = 1'b1; IR_READY = 1'b0;
        repeat (3) step();
        REDIR_VALID = 1'b1; REDIR_PC = 6'd3;
        step();
        REDIR_VALID = 1'b0;
        check("redir_valid", 64'(a_valid), 64'(0));
        check("redir_addr",  64'(a_addr),  64'(3));
        check("redir_state", 64'(a_state), 64'(1));
        step();
        check("redir_head_valid", 64'(a_valid), 64'(1));
        check("redir_head_pc",    64'(a_pc),    64'(3));
        check("redir_head_data",  64'(a_data),  64'(mem_word(6'd3)));

        // Asynchronous reset with two entries queued.
        step();
        check("pre_rst_state", 64'(a_state), 64'(2));
        #2 RST = 1'b1;
        #1;
        check("async_rst_valid", 64'(a_valid), 64'(0));
        check("async_rst_addr",  64'(a_addr),  64'(0));
        check("async_rst_state", 64'(a_state), 64'(0));
        RUN = 1'b0;
        repeat (2) step();
        RST = 1'b0;
        step();
        check("post_rst_idle",  64'(a_state), 64'(0));
        check("post_rst_addr",  64'(a_addr),  64'(0));
        check("post_rst_valid", 64'(a_valid), 64'(0));
        RUN = 1'b1; IR_READY = 1'b1;
        repeat (2) step();
        check("restart_pc", 64'(a_pc), 64'(0));
        check("restart_valid", 64'(a_valid), 64'(1));

`ifdef IFC_STALL_CNT_EN
        // Stall-cycle counter.
        do_reset();
        check("cnt_rst", 64'(a_stall_cnt), 64'(0));
        RUN = 1'b1; IR_READY = 1'b0;
        repeat (3) step();
        repeat (10) step();
        check("stall_cnt_10", 64'(a_stall_cnt), 64'(10));
`endif

        // Randomized run against a queue-level model (DEPTH 2, LAST_PC 7).
        do_reset();
        mq.delete();
        mode = 0;
        mpc  = 0;
        for (int c = 0; c < 600; c++) begin
            RUN = ($urandom_range(0, 7) != 0);
            IR_READY = 1'($urandom_range(0, 1));
            REDIR_VALID = ($urandom_range(0, 15) == 0);
            if (mode == 3 && mq.size() == 0 && $urandom_range(0, 1) == 1) REDIR_VALID = 1'b1;
            REDIR_PC = 6'($urandom_range(0, 63));

            if (REDIR_VALID) begin
                mq.delete();
                mpc = int'(REDIR_PC);
                if (mode != 0) mode = 1;
            end else begin
                m_pop  = (mq.size() > 0) && IR_READY;
                m_push = (mode == 1) && ((mq.size() < 2) || m_pop);
                m_last = 1'b0;
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back(mpc);
                    m_last = (mpc == 7);
                    mpc = (mpc + 1) % 64;
                end
                case (mode)
                    0: if (RUN) mode = 1;
                    1: begin
                        if (m_last) mode = 3;
                        else if (!RUN) mode = 0;
                        else if (mq.size() == 2 && !m_pop) mode = 2;
                    end
                    2: begin
                        if (!RUN) mode = 0;
                        else if (m_pop) mode = 1;
                    end
                    default: ;
                endcase
            end

            step();

            exp_v = {2'(mode), 6'(mpc), 1'(mq.size() > 0),
                     (mq.size() > 0) ? 6'(mq[0]) : 6'd0,
                     (mq.size() > 0) ? mem_word(6'(mq[0])) : 16'd0};
            act_v = {a_state, a_addr, a_valid,
                     a_valid ? a_pc : 6'd0,
                     a_valid ? a_data : 16'd0};
            check($sformatf("rand%0d", c), act_v, exp_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
